// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and helpers for the pipelined adder.
// Overflow rule lives here so every stage and user sees the same definition.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Signed overflow: operand MSBs agree but the result MSB does not.
  function automatic logic signed_overflow(input logic a_msb, input logic b_msb,
                                           input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// Combinational N-bit ripple slice: {carryout,sum} = a + b + carryin.
module adder_slice #(
  parameter int N = 8
) (
  output logic [N-1:0] sum,
  output logic         carryout,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carryin
);

  assign {carryout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carryin};

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract pipeline: one SLICE-bit chunk per stage, carry registered between
// stages, with a valid/ready interface and whole-pipeline freeze on output stall.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int SLICE = WIDTH / STAGES;

  if ((STAGES < 1) || (WIDTH < 2) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Handshake: input transfers when in_valid && in_ready, output retires when
  // out_valid && out_ready; the pipeline only stalls while a result is held.
  logic               advance;
  logic [STAGES:0]    v_q;
  logic [STAGES:0]    c_q;
  logic [WIDTH-1:0]   a_q [STAGES];
  logic [WIDTH-1:0]   b_q [STAGES];
  logic [WIDTH-1:0]   s_q [STAGES+1];
  logic [SLICE-1:0]   slice_sum [STAGES];
  logic [STAGES-1:0]  slice_co;
  logic [WIDTH-1:0]   final_sum;
  logic               ovf_q;
  logic               zero_q;

  assign in_ready = !(v_q[STAGES] && !out_ready);
  assign advance  = in_ready;

  // Register k holds k completed slices; stage k fills slice k into register k+1.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(.N(SLICE)) u_slice (
      .sum      (slice_sum[k]),
      .carryout (slice_co[k]),
      .a        (a_q[k][k*SLICE +: SLICE]),
      .b        (b_q[k][k*SLICE +: SLICE]),
      .carryin  (c_q[k])
    );
  end

  always_comb begin
    final_sum = s_q[STAGES-1];
    final_sum[WIDTH-1 -: SLICE] = slice_sum[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q    <= {v_q[STAGES-1:0], in_valid};
      a_q[0] <= a;
      b_q[0] <= subtract ? ~b : b;
      s_q[0] <= '0;
      c_q[0] <= subtract ? ~carryin : carryin;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 1; k <= STAGES; k++) begin
        s_q[k]                       <= s_q[k-1];
        s_q[k][(k-1)*SLICE +: SLICE] <= slice_sum[k-1];
        c_q[k]                       <= slice_co[k-1];
      end
      ovf_q  <= signed_overflow(a_q[STAGES-1][WIDTH-1], b_q[STAGES-1][WIDTH-1],
                                final_sum[WIDTH-1]);
      zero_q <= (final_sum == '0);
    end
  end

  assign out_valid = v_q[STAGES];
  assign sum       = s_q[STAGES];
  assign carryout  = c_q[STAGES];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, STAGES=4): driver pushes
// expected results from an arithmetic model, a monitor pops on every retire.
module tb_pipelined_adder;

  localparam int W = 8;
  localparam int S = 4;
  localparam int RW = W + 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carryin = 1'b0;
  logic         subtract = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;
  logic         zero;

  int checks = 0;
  int failures = 0;
  logic rand_ready = 1'b0;
  logic [RW-1:0] exp_q[$];

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carryin(carryin), .subtract(subtract),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Plain integer arithmetic; result packed as {carryout, overflow, zero, sum}.
  function automatic logic [RW-1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                          input logic xc, input logic xs);
    int ua, ub, ci, sa, sb, r, sr;
    logic co, ov;
    logic [W-1:0] s8;
    ua = int'(xa);
    ub = int'(xb);
    ci = xc ? 1 : 0;
    sa = $signed(xa);
    sb = $signed(xb);
    if (!xs) begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
      co = (r > 255);
    end else begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
      co = (ua >= ub + ci);
    end
    s8 = r[W-1:0];
    ov = (sr > 127) || (sr < -128);
    return {co, ov, (s8 == '0), s8};
  endfunction

  // ---------------- driver tasks (call at posedge + 1) ----------------
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xc, input logic xs);
    bit accepted;
    accepted = 0;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    carryin = xc;
    subtract = xs;
    for (int w = 0; w < 300 && !accepted; w++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(xa, xb, xc, xs));
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready never rose, required 1 within 300 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int w = 0; w < 500 && exp_q.size() != 0; w++) idle(1);
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s: %0d results outstanding, required 0", tag, exp_q.size());
    end
  endtask

  // Random backpressure, updated just after the driver's changes.
  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor / scoreboard ----------------
  logic          held = 1'b0;
  logic [RW-1:0] held_val;
  logic [RW-1:0] got;
  logic [RW-1:0] exp_v;

  always @(negedge clk) begin
    got = {carryout, overflow, zero, sum};
    if (reset) begin
      held = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        if (held) begin
          checks++;
          if (got !== held_val) begin
            failures++;
            $display("FAIL stall_stable: output %h changed, required %h", got, held_val);
          end
        end
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready: in_ready=%b while held, required 0", in_ready);
        end
        held = 1'b1;
        held_val = got;
      end else begin
        held = 1'b0;
      end
      if (!out_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL empty_in_ready: in_ready=%b with output empty, required 1", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result: got %h, required no result", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            failures++;
            $display("FAIL result {co,ov,z,sum}: got %h, required %h", got, exp_v);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] corner [5];
  int lat;

  initial begin
    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
    corner[3] = 8'h80; corner[4] = 8'hFF;

    // reset state
    idle(3);
    reset = 1'b0;
    checks++;
    if ({out_valid, sum, carryout, overflow, zero, in_ready} !== {1'b0, 8'h00, 4'b0001}) begin
      failures++;
      $display("FAIL reset_state: ov=%b sum=%h co=%b ovf=%b z=%b rdy=%b, required 0 00 0 0 0 1",
               out_valid, sum, carryout, overflow, zero, in_ready);
    end

    // latency of a lone transfer
    out_ready = 1'b1;
    send(8'h0F, 8'h01, 1'b0, 1'b0);
    lat = 0;
    for (int w = 0; w < 20; w++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    checks++;
    if (lat != S) begin
      failures++;
      $display("FAIL latency: out_valid after %0d edges, required %0d", lat, S);
    end
    wait_drain("latency");

    // directed arithmetic cases
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    send(8'h05, 8'h07, 1'b0, 1'b1);
    send(8'h05, 8'h07, 1'b1, 1'b1);
    send(8'h80, 8'h01, 1'b0, 1'b1);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_drain("directed");

    // back-to-back burst followed by a 5-cycle stall
    for (int i = 0; i < 16; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    out_ready = 1'b0;
    idle(5);
    out_ready = 1'b1;
    wait_drain("stall");

    // reset with three transfers in flight; a fourth presented during reset
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b1, 1'b0);
    send(8'h55, 8'h66, 1'b0, 1'b1);
    reset = 1'b1;
    in_valid = 1'b1;
    a = 8'h99; b = 8'h01; carryin = 1'b0; subtract = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flush: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    idle(12);

    // corner matrix and random sweep under random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int m = 0; m < 4; m++)
          send(corner[i], corner[j], m[0], m[1]);
    for (int i = 0; i < 1500; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    wait_drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
